branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 133 +++++++++++++
 tb/tb_branch_predictor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters and a zero-latency lookup.
// Define BP_STATS_EN to add the StatBranches/StatMispredicts counters.
module branch_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] LookupAddr,
  output logic        PCSource,
  output logic [31:0] Predict,
  input  logic        UpdEn,
  input  logic [31:0] UpdAddr,
  input  logic [31:0] UpdTarget,
  input  logic        UpdTaken
`ifdef BP_STATS_EN
  ,
  output logic [31:0] StatBranches,
  output logic [31:0] StatMispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx_s;
  logic             lk_hit_s;
  logic             lk_taken_s;

  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_hit_s;
  logic [1:0]       upd_ctr_s;
  logic [1:0]       ctr_d;
  logic             upd_wr_s;

  logic unused_s;
  assign unused_s = ^UpdAddr[1:0];

  // Lookup port: reset forces the fall-through prediction regardless of table contents.
  always_comb begin
    lk_idx_s   = LookupAddr[IDX_W+1:2];
    lk_hit_s   = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == LookupAddr[31:IDX_W+2]);
    lk_taken_s = lk_hit_s && ctr_q[lk_idx_s][1] && !Rst;
    PCSource   = lk_taken_s;
    if (lk_taken_s) begin
      Predict = target_q[lk_idx_s];
    end else begin
      Predict = LookupAddr + 32'd4;
    end
  end

  // Update port: read the pre-write entry and compute its next counter value.
  always_comb begin
    upd_idx_s = UpdAddr[IDX_W+1:2];
    upd_tag_s = UpdAddr[31:IDX_W+2];
    upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
    upd_ctr_s = ctr_q[upd_idx_s];
    upd_wr_s  = upd_hit_s || UpdTaken;
    if (upd_hit_s) begin
      if (UpdTaken) begin
        ctr_d = (upd_ctr_s == 2'b11) ? 2'b11 : upd_ctr_s + 2'b01;
      end else begin
        ctr_d = (upd_ctr_s == 2'b00) ? 2'b00 : upd_ctr_s - 2'b01;
      end
    end else if (UpdTaken) begin
      ctr_d = 2'b10;
    end else begin
      ctr_d = upd_ctr_s;
    end
  end

  // Valid bits and counters; reset leaves every entry invalid and weakly not-taken.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (UpdEn && upd_wr_s) begin
      valid_q[upd_idx_s] <= 1'b1;
      ctr_q[upd_idx_s]   <= ctr_d;
    end
  end

  // Tag and target need no reset since the valid bit gates them.
  always_ff @(posedge Clk) begin
    if (!Rst && UpdEn && UpdTaken) begin
      tag_q[upd_idx_s]    <= upd_tag_s;
      target_q[upd_idx_s] <= UpdTarget;
    end
  end

`ifdef BP_STATS_EN
  logic        upd_pred_taken_s;
  logic        mispredict_s;
  logic [31:0] br_cnt_q;
  logic [31:0] mp_cnt_q;

  // Mispredict is judged against the entry as it stood before this update.
  always_comb begin
    upd_pred_taken_s = upd_hit_s && upd_ctr_s[1];
    mispredict_s     = (upd_pred_taken_s != UpdTaken) ||
                       (upd_pred_taken_s && UpdTaken && (target_q[upd_idx_s] != UpdTarget));
  end

  // Wrapping event counters for resolved branches and mispredictions.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      br_cnt_q <= 32'd0;
      mp_cnt_q <= 32'd0;
    end else if (UpdEn) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict_s) begin
        mp_cnt_q <= mp_cnt_q + 32'd1;
      end else begin
        mp_cnt_q <= mp_cnt_q;
      end
    end else begin
      br_cnt_q <= br_cnt_q;
      mp_cnt_q <= mp_cnt_q;
    end
  end

  assign StatBranches    = br_cnt_q;
  assign StatMispredicts = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, stats sequence, then random traffic vs. a model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;

  logic        Clk;
  logic        Rst;
  logic [31:0] LookupAddr;
  logic        PCSource;
  logic [31:0] Predict;
  logic        UpdEn;
  logic [31:0] UpdAddr;
  logic [31:0] UpdTarget;
  logic        UpdTaken;
`ifdef BP_STATS_EN
  logic [31:0] StatBranches;
  logic [31:0] StatMispredicts;
`endif

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .LookupAddr(LookupAddr),
    .PCSource(PCSource),
    .Predict(Predict),
    .UpdEn(UpdEn),
    .UpdAddr(UpdAddr),
    .UpdTarget(UpdTarget),
    .UpdTaken(UpdTaken)
`ifdef BP_STATS_EN
    ,
    .StatBranches(StatBranches),
    .StatMispredicts(StatMispredicts)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: each slot remembers the full word address (addr >> 2) of its branch.
  bit          m_valid [ENTRIES];
  int unsigned m_word  [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_br = 0;
  int unsigned m_mp = 0;

  typedef struct {
    logic        rst;
    logic [31:0] look;
    logic        upd;
    logic [31:0] ua;
    logic [31:0] ut;
    logic        tk;
    logic        exp_pcs;
    logic [31:0] exp_pred;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic [31:0] look, input logic upd,
                         input logic [31:0] ua, input logic [31:0] ut, input logic tk,
                         input logic exp_pcs, input logic [31:0] exp_pred);
    vec_t v;
    v.rst = rst; v.look = look; v.upd = upd; v.ua = ua; v.ut = ut; v.tk = tk;
    v.exp_pcs = exp_pcs; v.exp_pred = exp_pred;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_look(input logic [31:0] a, output logic pcs, output logic [31:0] pred);
    int unsigned idx;
    idx = (a >> 2) % ENTRIES;
    pcs  = !Rst && m_valid[idx] && (m_word[idx] == (a >> 2)) && (m_ctr[idx] >= 2);
    pred = pcs ? m_tgt[idx] : a + 32'd4;
  endtask

  task automatic model_edge();
    int unsigned idx;
    bit hit, pred;
    if (Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_br = 0;
      m_mp = 0;
    end else if (UpdEn) begin
      idx  = (UpdAddr >> 2) % ENTRIES;
      hit  = m_valid[idx] && (m_word[idx] == (UpdAddr >> 2));
      pred = hit && (m_ctr[idx] >= 2);
      m_br++;
      if ((pred != UpdTaken) || (pred && UpdTaken && m_tgt[idx] != UpdTarget)) m_mp++;
      if (hit) begin
        if (UpdTaken) begin
          m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          m_tgt[idx] = UpdTarget;
        end else begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
      end else if (UpdTaken) begin
        m_valid[idx] = 1'b1;
        m_word[idx]  = UpdAddr >> 2;
        m_tgt[idx]   = UpdTarget;
        m_ctr[idx]   = 2;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] look, input logic upd,
                       input logic [31:0] ua, input logic [31:0] ut, input logic tk);
    Rst = rst; LookupAddr = look; UpdEn = upd; UpdAddr = ua; UpdTarget = ut; UpdTaken = tk;
    #2;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic check_stats();
`ifdef BP_STATS_EN
    check("stat_branches", StatBranches, m_br);
    check("stat_mispredicts", StatMispredicts, m_mp);
`endif
  endtask

  initial begin
    logic        e_pcs;
    logic [31:0] e_pred;
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_word[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end

    //       rst   look          upd   uaddr   utarget tk    pcs   predict
    add_vec(1'b1, 32'h00000040, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h00000044);
    add_vec(1'b0, 32'h00000040, 1'b1, 32'h40,  32'h100, 1'b1, 1'b0, 32'h00000044);
    add_vec(1'b0, 32'h00000040, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h00000100);
    add_vec(1'b0, 32'h00001234, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h00001238);
    add_vec(1'b0, 32'h00000040, 1'b1, 32'h40,  32'h100, 1'b0, 1'b1, 32'h00000100);
    add_vec(1'b0, 32'h00000040, 1'b1, 32'h40,  32'h100, 1'b1, 1'b0, 32'h00000044);
    add_vec(1'b0, 32'h00000040, 1'b1, 32'h40,  32'h100, 1'b1, 1'b1, 32'h00000100);
    add_vec(1'b0, 32'h00000040, 1'b1, 32'h40,  32'h100, 1'b0, 1'b1, 32'h00000100);
    add_vec(1'b0, 32'h00000040, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h00000100);
    add_vec(1'b0, 32'h00000040, 1'b1, 32'h40,  32'h180, 1'b1, 1'b1, 32'h00000100);
    add_vec(1'b0, 32'h00000040, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h00000180);
    add_vec(1'b0, 32'h00000140, 1'b1, 32'h140, 32'h200, 1'b1, 1'b0, 32'h00000144);
    add_vec(1'b0, 32'h00000040, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h00000044);
    add_vec(1'b0, 32'h00000140, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h00000200);
    add_vec(1'b0, 32'h00000143, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h00000200);
    add_vec(1'b0, 32'h00000080, 1'b1, 32'h80,  32'h900, 1'b0, 1'b0, 32'h00000084);
    add_vec(1'b0, 32'h00000080, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h00000084);
    add_vec(1'b1, 32'h00000140, 1'b1, 32'h300, 32'h500, 1'b1, 1'b0, 32'h00000144);
    add_vec(1'b0, 32'h00000300, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h00000304);
    add_vec(1'b0, 32'h00000140, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h00000144);
    add_vec(1'b0, 32'hFFFFFFFC, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h00000000);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].look, vecs[i].upd, vecs[i].ua, vecs[i].ut, vecs[i].tk);
      check($sformatf("vec%0d_pcsource", i), {31'd0, PCSource}, {31'd0, vecs[i].exp_pcs});
      check($sformatf("vec%0d_predict", i), Predict, vecs[i].exp_pred);
      if (!vecs[i].rst) check_stats();
      tick();
    end

    // Stats sequence: three resolved branches with one mispredict, then reset with an update.
    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 32'h40, 32'h0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 32'h80, 32'h0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 32'h40, 32'h100, 1'b1); tick();
    drive(1'b1, 32'h40, 1'b1, 32'h140, 32'h300, 1'b1);
`ifdef BP_STATS_EN
    check("seq_branches_before", StatBranches, 32'd3);
    check("seq_mispredicts_before", StatMispredicts, 32'd1);
`endif
    check("seq_rst_pcsource", {31'd0, PCSource}, 32'd0);
    check("seq_rst_predict", Predict, 32'h00000044);
    tick();
    drive(1'b0, 32'h140, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef BP_STATS_EN
    check("seq_branches_after", StatBranches, 32'd0);
    check("seq_mispredicts_after", StatMispredicts, 32'd0);
`endif
    check("seq_no_alloc_pcsource", {31'd0, PCSource}, 32'd0);
    check("seq_no_alloc_predict", Predict, 32'h00000144);
    tick();

    // Random traffic over a small address pool so hits, aliases and saturation all occur.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] la, ua, ut;
      la = ($urandom_range(0, 3) << (2 + 6)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      ua = ($urandom_range(0, 3) << (2 + 6)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      ut = {$urandom_range(0, 3), 2'b00} + 32'h1000;
      drive(($urandom_range(0, 149) == 0), la, $urandom_range(0, 1), ua, ut, $urandom_range(0, 2) != 0);
      model_look(la, e_pcs, e_pred);
      check("rand_pcsource", {31'd0, PCSource}, {31'd0, e_pcs});
      check("rand_predict", Predict, e_pred);
      check_stats();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
